data_sram_responder: RTL and testbench

- Responder end of the single-cycle core's data-memory interface: a 128x32 word-addressed data memory.
- Serves the core's active-low CEN/WEN/OEN strobe port with same-cycle read data and posedge writes.
- A secondary host port, with a valid/ready handshake, preloads and inspects memory from the testbench/loader whenever the core is not accessing it.
- Saturating access counters support performance checks.

---
 rtl/data_sram_responder_if.sv | 35 +++
 rtl/data_sram_responder.sv | 109 ++++++++++
 tb/tb_data_sram_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// Core strobe port plus host valid/ready port of the data SRAM responder.
// The responder side uses the slave modport; the core/loader side uses master.
interface data_sram_responder_if #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  logic          CEN;
  logic          WEN;
  logic          OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  logic          host_valid;
  logic          host_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_done;
  logic [DW-1:0] host_rdata;

  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;

  modport master (
    output CEN, WEN, OEN, A, D, host_valid, host_we, host_addr, host_wdata,
    input  Q, host_ready, host_done, host_rdata, rd_cnt, wr_cnt
  );

  modport slave (
    input  CEN, WEN, OEN, A, D, host_valid, host_we, host_addr, host_wdata,
    output Q, host_ready, host_done, host_rdata, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed data SRAM: zero-latency core reads, posedge writes, host done one cycle after accept.
// Core strobes always win; host_ready drops whenever CEN=0 and while a host response is in flight.
module data_sram_responder #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  data_sram_responder_if.slave bus
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DW-1:0]    host_rdata_q, host_rdata_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic core_rd;
  logic core_wr;
  logic host_ready;
  logic host_done;
  logic host_acc;

  assign core_rd  = !bus.CEN && bus.WEN;
  assign core_wr  = !bus.CEN && !bus.WEN;
  assign host_acc = bus.host_valid && host_ready;

  // The core samples Q in the same cycle it drives the strobes.
  assign bus.Q = (core_rd && !bus.OEN) ? mem_q[bus.A] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host_acc) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host_ready = 1'b0;
    host_done  = 1'b0;
    case (state_q)
      IDLE:    host_ready = bus.CEN;
      RESP:    host_done  = 1'b1;
      default: ;
    endcase
  end

  // host_acc implies CEN=1, so at most one writer reaches the array per edge.
  always_comb begin
    mem_d = mem_q;
    if (core_wr) begin
      mem_d[bus.A] = bus.D;
    end else if (host_acc && bus.host_we) begin
      mem_d[bus.host_addr] = bus.host_wdata;
    end
  end

  always_comb begin
    host_rdata_d = host_rdata_q;
    if (host_acc && !bus.host_we) begin
      host_rdata_d = mem_q[bus.host_addr];
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (core_rd && rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if (core_wr && wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q        <= '{default: '0};
      host_rdata_q <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      mem_q        <= mem_d;
      host_rdata_q <= host_rdata_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  assign bus.host_ready = host_ready;
  assign bus.host_done  = host_done;
  assign bus.host_rdata = host_rdata_q;
  assign bus.rd_cnt     = rd_cnt_q;
  assign bus.wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed and randomized checks of data_sram_responder against a word-array reference model.
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_sram_responder_if #(.AW(7), .DW(32), .CNT_W(16)) bus ();
  data_sram_responder_if #(.AW(7), .DW(32), .CNT_W(4))  bus4 ();

  data_sram_responder #(.AW(7), .DW(32), .DEPTH(128), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  data_sram_responder #(.AW(7), .DW(32), .DEPTH(128), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mm [128];
  int          rd_m;
  int          wr_m;
  logic [31:0] hr_m;
  bit          done_m;
  bit          pend;
  bit          acc;
  logic [31:0] exp_q;
  bit          exp_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.CEN = 1'b1; bus.WEN = 1'b1; bus.OEN = 1'b0; bus.A = '0; bus.D = '0;
    bus.host_valid = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus4.CEN = 1'b1; bus4.WEN = 1'b1; bus4.OEN = 1'b0; bus4.A = '0; bus4.D = '0;
    bus4.host_valid = 1'b0; bus4.host_we = 1'b0; bus4.host_addr = '0; bus4.host_wdata = '0;

    // reset state
    tick(); tick();
    chk("rst_done", bus.host_done, 0);
    chk("rst_rdata", bus.host_rdata, 0);
    chk("rst_rd_cnt", bus.rd_cnt, 0);
    chk("rst_wr_cnt", bus.wr_cnt, 0);
    chk("rst_ready", bus.host_ready, 1);
    bus.CEN = 1'b0; bus.A = 7'd5;
    #1 chk("rst_q_cleared", bus.Q, 0);
    bus.CEN = 1'b1;
    rst = 1'b0;

    // 1: host preload then same-cycle core read
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 7'd5; bus.host_wdata = 32'hDEADBEEF;
    #1 chk("t1_ready", bus.host_ready, 1);
    chk("t1_done_pre", bus.host_done, 0);
    tick();
    bus.host_valid = 1'b0;
    #1 chk("t1_done", bus.host_done, 1);
    chk("t1_ready_resp", bus.host_ready, 0);
    tick();
    chk("t1_done_clr", bus.host_done, 0);
    bus.CEN = 1'b0; bus.WEN = 1'b1; bus.OEN = 1'b0; bus.A = 7'd5;
    #1 chk("t1_q", bus.Q, 32'hDEADBEEF);
    chk("t1_ready_core", bus.host_ready, 0);
    tick();
    chk("t1_rd_cnt", bus.rd_cnt, 1);

    // 2: core write at top address, read back, OEN gating
    bus.WEN = 1'b0; bus.A = 7'd127; bus.D = 32'h12345678;
    #1 chk("t2_q_during_wr", bus.Q, 0);
    tick();
    bus.WEN = 1'b1;
    #1 chk("t2_q", bus.Q, 32'h12345678);
    chk("t2_wr_cnt", bus.wr_cnt, 1);
    bus.OEN = 1'b1;
    #1 chk("t2_q_oen", bus.Q, 0);
    bus.OEN = 1'b0;
    tick();
    chk("t2_rd_cnt", bus.rd_cnt, 2);

    // 3: core reads hold off a host write
    bus.A = 7'd5;
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 7'd3; bus.host_wdata = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_held_off", bus.host_ready, 0);
      chk("t3_q", bus.Q, 32'hDEADBEEF);
      tick();
    end
    bus.CEN = 1'b1;
    #1 chk("t3_ready", bus.host_ready, 1);
    tick();
    bus.host_valid = 1'b0;
    chk("t3_done", bus.host_done, 1);
    tick();
    chk("t3_done_clr", bus.host_done, 0);
    bus.CEN = 1'b0; bus.A = 7'd3;
    #1 chk("t3_mem3", bus.Q, 32'h0BADF00D);
    tick();
    bus.CEN = 1'b1;

    // 4: host reads, back to back
    bus.CEN = 1'b0; bus.WEN = 1'b0; bus.A = 7'd0; bus.D = 32'hA5A5A5A5;
    tick();
    bus.CEN = 1'b1; bus.WEN = 1'b1;
    bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 7'd0;
    #1 chk("t4_ready", bus.host_ready, 1);
    tick();
    bus.host_addr = 7'd5;
    #1 chk("t4_done", bus.host_done, 1);
    chk("t4_rdata", bus.host_rdata, 32'hA5A5A5A5);
    chk("t4_ready_resp", bus.host_ready, 0);
    tick();
    chk("t4_done_gap", bus.host_done, 0);
    chk("t4_rdata_hold", bus.host_rdata, 32'hA5A5A5A5);
    tick();
    bus.host_valid = 1'b0;
    chk("t4_done2", bus.host_done, 1);
    chk("t4_rdata2", bus.host_rdata, 32'hDEADBEEF);
    tick();
    chk("t4_rdata_hold2", bus.host_rdata, 32'hDEADBEEF);
    chk("t4_rd_cnt", bus.rd_cnt, 7);
    chk("t4_wr_cnt", bus.wr_cnt, 2);

    // 5: async reset while a host response is pending
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 7'd9; bus.host_wdata = 32'h55AA55AA;
    tick();
    bus.host_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("t5_done", bus.host_done, 0);
    chk("t5_rd_cnt", bus.rd_cnt, 0);
    chk("t5_wr_cnt", bus.wr_cnt, 0);
    chk("t5_rdata", bus.host_rdata, 0);
    bus.CEN = 1'b0; bus.A = 7'd9;
    #1 chk("t5_word", bus.Q, 0);
    bus.CEN = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_done_after", bus.host_done, 0);
    bus.CEN = 1'b0;
    #1 chk("t5_word_after", bus.Q, 0);
    bus.CEN = 1'b1;
    // rst released after the last edge, so this reset-cleared state is the model baseline
    rst = 1'b1;
    #1 rst = 1'b0;

    // randomized traffic against the word-array model
    for (int i = 0; i < 128; i++) mm[i] = '0;
    rd_m = 0; wr_m = 0; hr_m = '0; done_m = 0; pend = 0;
    for (int c = 0; c < 400; c++) begin
      bus.CEN = 1'($urandom_range(0, 1));
      bus.WEN = 1'($urandom_range(0, 1));
      bus.OEN = ($urandom_range(0, 3) == 0);
      bus.A   = 7'($urandom_range(0, 15));
      bus.D   = $urandom;
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1;
        bus.host_valid = 1'b1;
        bus.host_we    = 1'($urandom_range(0, 1));
        bus.host_addr  = 7'($urandom_range(0, 15));
        bus.host_wdata = $urandom;
      end
      #1;
      exp_q     = (!bus.CEN && bus.WEN && !bus.OEN) ? mm[bus.A] : 32'h0;
      exp_ready = !done_m && bus.CEN;
      chk("rnd_q", bus.Q, exp_q);
      chk("rnd_ready", bus.host_ready, exp_ready);
      chk("rnd_done", bus.host_done, done_m);
      chk("rnd_rdata", bus.host_rdata, hr_m);
      chk("rnd_rd_cnt", bus.rd_cnt, rd_m);
      chk("rnd_wr_cnt", bus.wr_cnt, wr_m);
      bus.OEN = 1'b0;
      acc = bus.host_valid && exp_ready;
      if (!bus.CEN && !bus.WEN) begin
        mm[bus.A] = bus.D;
        wr_m++;
      end
      if (!bus.CEN && bus.WEN) rd_m++;
      if (acc) begin
        if (bus.host_we) mm[bus.host_addr] = bus.host_wdata;
        else             hr_m = mm[bus.host_addr];
      end
      done_m = acc;
      tick();
      if (acc) begin
        pend = 0;
        bus.host_valid = 1'b0;
      end
    end
    bus.CEN = 1'b1;
    bus.host_valid = 1'b0;

    // 6: 4-bit counters saturate
    chk("t6_rd_cnt0", bus4.rd_cnt, 0);
    bus4.CEN = 1'b0; bus4.WEN = 1'b1; bus4.OEN = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      bus4.A = 7'($urandom_range(0, 127));
      tick();
      chk("t6_rd_cnt", bus4.rd_cnt, (n > 15) ? 15 : n);
    end
    bus4.CEN = 1'b1;
    tick();
    chk("t6_rd_hold", bus4.rd_cnt, 15);
    chk("t6_wr_cnt", bus4.wr_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
